// File: rtl/aes_key_expand_pkg.sv
// AES-128 key schedule: shared constants, FSM state type, S-box table and RCON lookup.
package aes_key_expand_pkg;

    localparam int unsigned NR       = 10;
    localparam int unsigned RK_IDX_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } state_e;

    // Forward AES S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
    endfunction

    // Round constant used to derive round key i+1 from round key i.
    function automatic logic [7:0] rcon(input logic [RK_IDX_W-1:0] i);
        logic [7:0] r;
        case (i)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// Key-in / round-key-out handshake bundle for the AES-128 key schedule.
interface aes_key_expand_if;
    import aes_key_expand_pkg::*;

    logic                key_valid;
    logic                key_ready;
    logic [127:0]        key_in;
    logic                rk_valid;
    logic                rk_ready;
    logic [127:0]        rk_data;
    logic [RK_IDX_W-1:0] rk_idx;
    logic                rk_last;
    logic                busy;

    modport master (
        output key_valid, key_in, rk_ready,
        input  key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
    );

    modport slave (
        input  key_valid, key_in, rk_ready,
        output key_ready, rk_valid, rk_data, rk_idx, rk_last, busy
    );
endinterface

// File: rtl/aes_key_expand_subword.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word; purely combinational.
module aes_key_expand_subword
    import aes_key_expand_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    // One S-box lookup per byte lane.
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        assign word_out[8*b +: 8] = sbox(word_in[8*b +: 8]);
    end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: accepts a cipher key and streams round keys 0..10.
// Optional macro AES_KEYEXP_STALL_EN: honour rk_ready backpressure; when
// undefined rk_ready is ignored and the 11 keys go out on consecutive cycles.
module aes_key_expand
    import aes_key_expand_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    aes_key_expand_if.slave bus
);

    state_e              state_q, state_d;
    logic [127:0]        rk_q, rk_d;
    logic [RK_IDX_W-1:0] idx_q, idx_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;

    logic                advance;
    logic [31:0]         rot_w3;
    logic [31:0]         sub_w3;
    logic [31:0]         temp_w;
    logic [31:0]         nw0, nw1, nw2, nw3;
    logic [127:0]        next_rk;

`ifdef AES_KEYEXP_STALL_EN
    assign advance = valid_q & bus.rk_ready;
`else
    logic unused_rk_ready;
    assign unused_rk_ready = bus.rk_ready;
    assign advance = valid_q;
`endif

    // RotWord on w3 followed by SubWord.
    assign rot_w3 = {rk_q[23:0], rk_q[31:24]};

    aes_key_expand_subword u_subword (
        .word_in  (rot_w3),
        .word_out (sub_w3)
    );

    // Derive round key idx+1 from the currently presented round key.
    always_comb begin
        temp_w  = sub_w3 ^ {rcon(idx_q), 24'h000000};
        nw0     = rk_q[127:96] ^ temp_w;
        nw1     = rk_q[95:64]  ^ nw0;
        nw2     = rk_q[63:32]  ^ nw1;
        nw3     = rk_q[31:0]   ^ nw2;
        next_rk = {nw0, nw1, nw2, nw3};
    end

    // Next-state, round counter and output register update.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.key_valid) begin
                    state_d = ST_EXPAND;
                    rk_d    = bus.key_in;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            ST_EXPAND: begin
                if (advance) begin
                    if (idx_q == RK_IDX_W'(NR)) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        rk_d    = next_rk;
                        idx_d   = idx_q + 1'b1;
                        last_d  = (idx_q == RK_IDX_W'(NR - 1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.key_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_EXPAND);
    assign bus.rk_valid  = valid_q;
    assign bus.rk_data   = rk_q;
    assign bus.rk_idx    = idx_q;
    assign bus.rk_last   = last_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: directed FIPS-197 vectors plus random
// keys, checked against a word-level key schedule built from a computed S-box.
module tb_aes_key_expand;

    logic clk = 1'b0;
    logic rst = 1'b1;

    aes_key_expand_if bus ();

    aes_key_expand dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]   sbox_tab [256];
    logic [127:0] obs_rk   [11];

    localparam logic [127:0] V1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V2 = 128'h0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        return (x << k) | (x >> (8 - k));
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Classic 44-word key expansion.
    task automatic ref_schedule(input logic [127:0] key, output logic [127:0] rk [11]);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Consume one schedule. Key must already be presented (key_valid=1) before the call.
    task automatic collect(input logic [127:0] key, input int stall_at, input int stall_len,
                           input bit poke, input int abort_at, input bit hold,
                           input logic [127:0] next_key);
        logic [127:0] exp_rk [11];
        int  n       = 0;
        int  stalled = 0;
        int  waits   = 0;
        int  budget  = 100;
        bit  seen    = 0;
        bit  poked   = 0;
        bit  aborted = 0;
        bit  eff;
        ref_schedule(key, exp_rk);
        while (n < 11 && budget > 0) begin
            @(negedge clk);
            budget--;
            if (bus.rk_valid) begin
                if (!seen) begin
                    check("first_key_latency", 128'(waits), 128'd0);
                    seen = 1;
                    if (hold) bus.key_in = next_key;
                    else      bus.key_valid = 1'b0;
                end
                check($sformatf("rk_idx[%0d]", n),  128'(bus.rk_idx),  128'(n));
                check($sformatf("rk_data[%0d]", n), bus.rk_data,       exp_rk[n]);
                check($sformatf("rk_last[%0d]", n), 128'(bus.rk_last), 128'(n == 10));
                check($sformatf("key_ready_busy[%0d]", n),
                      128'({bus.key_ready, bus.busy}), 128'(2'b01));
                obs_rk[n] = bus.rk_data;
                if (n == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check("rst_rk_valid",  128'(bus.rk_valid),  128'd0);
                    check("rst_key_ready", 128'(bus.key_ready), 128'd1);
                    check("rst_rk_data",   bus.rk_data,         128'd0);
                    check("rst_rk_idx",    128'(bus.rk_idx),    128'd0);
                    check("rst_rk_last",   128'(bus.rk_last),   128'd0);
                    check("rst_busy",      128'(bus.busy),      128'd0);
                    aborted = 1;
                    break;
                end
                if (poke) begin
                    if (n == 4 && !poked) begin
                        bus.key_valid = 1'b1;
                        bus.key_in    = ~key;
                        poked = 1;
                    end else begin
                        bus.key_valid = 1'b0;
                    end
                end
            end else begin
                waits++;
            end
            if (n == stall_at && stalled < stall_len) begin
                bus.rk_ready = 1'b0;
                stalled++;
            end else begin
                bus.rk_ready = 1'b1;
            end
`ifdef AES_KEYEXP_STALL_EN
            eff = bus.rk_ready;
`else
            eff = 1'b1;
`endif
            if (bus.rk_valid && eff) n++;
        end
        bus.rk_ready = 1'b1;
        if (!aborted) begin
            check("schedule_complete", 128'(n), 128'd11);
            @(negedge clk);
            check("post_last_rk_valid",  128'(bus.rk_valid),  128'd0);
            check("post_last_key_ready", 128'(bus.key_ready), 128'd1);
            check("post_last_busy",      128'(bus.busy),      128'd0);
        end
    endtask

    task automatic present_key(input logic [127:0] key);
        @(negedge clk);
        bus.key_valid = 1'b1;
        bus.key_in    = key;
    endtask

    initial begin
        logic [127:0] rkey;
        bus.key_valid = 1'b0;
        bus.key_in    = '0;
        bus.rk_ready  = 1'b1;
        build_sbox();

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_key_ready", 128'(bus.key_ready), 128'd1);
        check("reset_rk_valid",  128'(bus.rk_valid),  128'd0);
        check("reset_rk_data",   bus.rk_data,         128'd0);
        check("reset_rk_idx",    128'(bus.rk_idx),    128'd0);
        check("reset_rk_last",   128'(bus.rk_last),   128'd0);
        check("reset_busy",      128'(bus.busy),      128'd0);
        rst = 1'b0;

        // FIPS-197 vector, no stall
        present_key(V1);
        collect(V1, -1, 0, 0, -1, 0, '0);
        check("v1_idx0",  obs_rk[0],  V1);
        check("v1_idx1",  obs_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("v1_idx10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero key
        present_key(V2);
        collect(V2, -1, 0, 0, -1, 0, '0);
        check("v2_idx1",  obs_rk[1],  128'h62636363626363636263636362636363);
        check("v2_idx10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // rk_ready low for 5 cycles at idx3
        present_key(V1);
        collect(V1, 3, 5, 0, -1, 0, '0);
        check("stall_v1_idx10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Foreign key pulsed during expansion is ignored
        present_key(V1);
        collect(V1, -1, 0, 1, -1, 0, '0);
        check("poke_v1_idx10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Reset at idx6, then no stray keys, then a fresh schedule
        present_key(V1);
        collect(V1, -1, 0, 0, 6, 0, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("after_rst_no_keys", 128'(bus.rk_valid), 128'd0);
        end
        present_key(V2);
        collect(V2, -1, 0, 0, -1, 0, '0);

        // Back-to-back keys with key_valid held
        present_key(V1);
        collect(V1, -1, 0, 0, -1, 1, V2);
        collect(V2, -1, 0, 0, -1, 0, '0);
        check("b2b_v2_idx10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Random keys with random stall placement
        for (int r = 0; r < 4; r++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            present_key(rkey);
            collect(rkey, int'($urandom_range(0, 10)), int'($urandom_range(0, 4)),
                    0, -1, 0, '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
